// File: rtl/uart_cmd_framer_if.sv
// Register-file write port of uart_cmd_framer. Signal names follow the framer's view
// (the framer drives the _o signals, the register file drives wr_ready_i).
`timescale 1ns/1ps

interface uart_cmd_framer_if;
  logic [7:0]  wr_addr_o;
  logic [15:0] wr_data_o;
  logic        wr_valid_o;
  logic        wr_ready_i;

  modport master (output wr_addr_o, output wr_data_o, output wr_valid_o, input wr_ready_i);
  modport slave  (input wr_addr_o, input wr_data_o, input wr_valid_o, output wr_ready_i);
endinterface

// File: rtl/uart_cmd_framer.sv
// Assembles UART bytes (SYNC, addr, data_hi, data_lo[, xor checksum]) into register writes.
// Define UART_CMD_FRAMER_CHECKSUM_EN to require the trailing XOR checksum byte.
`timescale 1ns/1ps

module uart_cmd_framer #(
  parameter int          TIMEOUT_CLOCKS = 1000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               rx_data_i,
  input  logic                     rx_valid_i,
  uart_cmd_framer_if.master        wr,
  output logic                     err_o,
  output logic [1:0]               err_code_o,
  output logic [7:0]               err_count_o,
  output logic                     busy_o
);

  localparam int             CW       = $clog2(TIMEOUT_CLOCKS + 1);
  localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT_CLOCKS - 1);
  localparam logic [CW-1:0]  TMO_ONE  = CW'(1);

  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;
  localparam logic [1:0] ERR_OVERRUN  = 2'd3;

`ifdef UART_CMD_FRAMER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DHI   = 3'd2,
    S_DLO   = 3'd3,
    S_CSUM  = 3'd4,
    S_ISSUE = 3'd5
  } state_t;
  localparam state_t S_AFTER_DLO = S_CSUM;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DHI   = 3'd2,
    S_DLO   = 3'd3,
    S_ISSUE = 3'd5
  } state_t;
  localparam state_t S_AFTER_DLO = S_ISSUE;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      dhi_q, dhi_d;
  logic [7:0]      dlo_q, dlo_d;
  logic            err_q;
  logic [1:0]      err_code_q;
  logic [7:0]      err_count_q;
  logic            err_set;
  logic [1:0]      err_set_code;
  logic            sync_seen;

  assign sync_seen = rx_valid_i && (rx_data_i == SYNC_BYTE);

`ifdef UART_CMD_FRAMER_CHECKSUM_EN
  logic [7:0] acc_q, acc_d;

  // Held at zero outside a packet, so it is already clear when a SYNC byte starts one.
  always_comb begin
    acc_d = acc_q;
    if (state_q == S_IDLE || state_q == S_ISSUE) begin
      acc_d = 8'h00;
    end else if (rx_valid_i && state_q != S_CSUM) begin
      acc_d = acc_q ^ rx_data_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= 8'h00;
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    addr_d       = addr_q;
    dhi_d        = dhi_q;
    dlo_d        = dlo_q;
    err_set      = 1'b0;
    err_set_code = 2'd0;

    unique case (state_q)
      S_IDLE: begin
        if (sync_seen) begin
          state_d = S_ADDR;
          tmo_d   = '0;
        end
      end

      S_ISSUE: begin
        // A byte coinciding with the accepted write is treated as if received in IDLE.
        if (wr.wr_ready_i) begin
          state_d = S_IDLE;
          if (sync_seen) begin
            state_d = S_ADDR;
            tmo_d   = '0;
          end
        end else if (rx_valid_i) begin
          err_set      = 1'b1;
          err_set_code = ERR_OVERRUN;
        end
      end

      default: begin
        if (rx_valid_i) begin
          tmo_d = '0;
          case (state_q)
            S_ADDR: begin
              addr_d  = rx_data_i;
              state_d = S_DHI;
            end
            S_DHI: begin
              dhi_d   = rx_data_i;
              state_d = S_DLO;
            end
            S_DLO: begin
              dlo_d   = rx_data_i;
              state_d = S_AFTER_DLO;
            end
`ifdef UART_CMD_FRAMER_CHECKSUM_EN
            S_CSUM: begin
              if (rx_data_i == acc_q) begin
                state_d = S_ISSUE;
              end else begin
                state_d      = S_IDLE;
                err_set      = 1'b1;
                err_set_code = ERR_CHECKSUM;
              end
            end
`endif
            default: state_d = S_IDLE;
          endcase
        end else if (tmo_q == TMO_LAST) begin
          state_d      = S_IDLE;
          err_set      = 1'b1;
          err_set_code = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      addr_q      <= 8'h00;
      dhi_q       <= 8'h00;
      dlo_q       <= 8'h00;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
      err_count_q <= 8'h00;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      dhi_q   <= dhi_d;
      dlo_q   <= dlo_d;
      err_q   <= err_set;
      if (err_set) begin
        err_code_q <= err_set_code;
        if (err_count_q != 8'hFF) begin
          err_count_q <= err_count_q + 8'd1;
        end
      end
    end
  end

  assign wr.wr_addr_o  = addr_q;
  assign wr.wr_data_o  = {dhi_q, dlo_q};
  assign wr.wr_valid_o = (state_q == S_ISSUE);
  assign err_o         = err_q;
  assign err_code_o    = err_code_q;
  assign err_count_o   = err_count_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Self-checking bench for uart_cmd_framer: directed scenarios plus randomized packets
// checked against a packet-level reference model.
`timescale 1ns/1ps

module tb_uart_cmd_framer;
  localparam int         TMO  = 16;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       err_o;
  logic [1:0] err_code;
  logic [7:0] err_count;
  logic       busy;

  int checks = 0;
  int failures = 0;

  logic [23:0] wr_log[$];
  logic [1:0]  err_log[$];

  uart_cmd_framer_if wr_bus();

  uart_cmd_framer #(.TIMEOUT_CLOCKS(TMO), .SYNC_BYTE(SYNC)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .wr          (wr_bus),
    .err_o       (err_o),
    .err_code_o  (err_code),
    .err_count_o (err_count),
    .busy_o      (busy)
  );

  always #5 clock = ~clock;

  // Observe transfers and error pulses mid-cycle, where inputs and outputs are stable.
  always @(negedge clock) begin
    if (!reset) begin
      if (wr_bus.wr_valid_o && wr_bus.wr_ready_i) begin
        wr_log.push_back({wr_bus.wr_addr_o, wr_bus.wr_data_o});
        $display("write addr=%02h data=%04h", wr_bus.wr_addr_o, wr_bus.wr_data_o);
      end
      if (err_o) err_log.push_back(err_code);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] xsum(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l);
    return a ^ h ^ l;
  endfunction

  task automatic send_packet(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l, input bit bad);
    send_byte(SYNC);
    send_byte(a);
    send_byte(h);
    send_byte(l);
`ifdef UART_CMD_FRAMER_CHECKSUM_EN
    send_byte(bad ? (xsum(a, h, l) ^ 8'h01) : xsum(a, h, l));
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_bus.wr_ready_i = 1'b0;
    tick(2);
    reset = 1'b0;
    wr_log.delete();
    err_log.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (wr_bus.wr_valid_o !== 1'b0) begin failures++; $display("FAIL reset_wr_valid got=%0h exp=0", wr_bus.wr_valid_o); end
    checks++; if (wr_bus.wr_addr_o !== 8'h00) begin failures++; $display("FAIL reset_wr_addr got=%02h exp=00", wr_bus.wr_addr_o); end
    checks++; if (wr_bus.wr_data_o !== 16'h0000) begin failures++; $display("FAIL reset_wr_data got=%04h exp=0000", wr_bus.wr_data_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", err_o); end
    checks++; if (err_code !== 2'd0) begin failures++; $display("FAIL reset_err_code got=%0d exp=0", err_code); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
  endtask

  task automatic test_good_packet();
    do_reset();
    wr_bus.wr_ready_i = 1'b1;
    send_packet(8'h12, 8'h34, 8'h56, 1'b0);
    checks++; if (wr_bus.wr_valid_o !== 1'b1) begin failures++; $display("FAIL good_valid got=%0h exp=1", wr_bus.wr_valid_o); end
    checks++; if (wr_bus.wr_addr_o !== 8'h12) begin failures++; $display("FAIL good_addr got=%02h exp=12", wr_bus.wr_addr_o); end
    checks++; if (wr_bus.wr_data_o !== 16'h3456) begin failures++; $display("FAIL good_data got=%04h exp=3456", wr_bus.wr_data_o); end
    tick(1);
    checks++; if (wr_bus.wr_valid_o !== 1'b0) begin failures++; $display("FAIL good_valid_drop got=%0h exp=0", wr_bus.wr_valid_o); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL good_busy got=%0h exp=0", busy); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL good_err_count got=%0d exp=0", err_count); end
    checks++; if (wr_log.size() !== 1) begin failures++; $display("FAIL good_write_count got=%0d exp=1", wr_log.size()); end
    wr_bus.wr_ready_i = 1'b0;
  endtask

  task automatic test_bad_checksum();
`ifdef UART_CMD_FRAMER_CHECKSUM_EN
    do_reset();
    wr_bus.wr_ready_i = 1'b1;
    send_packet(8'h12, 8'h34, 8'h56, 1'b1);
    checks++; if (wr_bus.wr_valid_o !== 1'b0) begin failures++; $display("FAIL badck_valid got=%0h exp=0", wr_bus.wr_valid_o); end
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL badck_err got=%0h exp=1", err_o); end
    checks++; if (err_code !== 2'd2) begin failures++; $display("FAIL badck_code got=%0d exp=2", err_code); end
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL badck_count got=%0d exp=1", err_count); end
    tick(1);
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL badck_err_pulse got=%0h exp=0", err_o); end
    send_packet(8'hAB, 8'hCD, 8'hEF, 1'b0);
    checks++; if (wr_bus.wr_valid_o !== 1'b1) begin failures++; $display("FAIL badck_next_valid got=%0h exp=1", wr_bus.wr_valid_o); end
    tick(1);
    checks++; if (wr_log.size() !== 1 || wr_log[0] !== 24'hABCDEF) begin failures++; $display("FAIL badck_next_write got=%0d entries exp=1 entry ABCDEF", wr_log.size()); end
    wr_bus.wr_ready_i = 1'b0;
`endif
  endtask

  task automatic test_timeout();
    do_reset();
    wr_bus.wr_ready_i = 1'b1;
    send_byte(SYNC);
    send_byte(8'h12);
    tick(TMO - 1);
    checks++; if (err_o !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL tmo_early got err=%0h busy=%0h exp err=0 busy=1", err_o, busy); end
    tick(1);
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL tmo_err got=%0h exp=1", err_o); end
    checks++; if (err_code !== 2'd1) begin failures++; $display("FAIL tmo_code got=%0d exp=1", err_code); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tmo_busy got=%0h exp=0", busy); end
    // Next byte lands in the expiry cycle itself and must win over the timeout.
    send_byte(SYNC);
    send_byte(8'h12);
    tick(TMO - 1);
    send_byte(8'h34);
    checks++; if (err_o !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL tmo_edge_byte got err=%0h busy=%0h exp err=0 busy=1", err_o, busy); end
    send_byte(8'h56);
`ifdef UART_CMD_FRAMER_CHECKSUM_EN
    send_byte(xsum(8'h12, 8'h34, 8'h56));
`endif
    tick(1);
    checks++; if (wr_log.size() !== 1 || err_count !== 8'd1) begin failures++; $display("FAIL tmo_edge_write got writes=%0d count=%0d exp writes=1 count=1", wr_log.size(), err_count); end
    wr_bus.wr_ready_i = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    send_packet(8'h12, 8'h34, 8'h56, 1'b0);
    tick(3);
    checks++; if (wr_bus.wr_valid_o !== 1'b1) begin failures++; $display("FAIL ovr_hold_valid got=%0h exp=1", wr_bus.wr_valid_o); end
    send_byte(8'hFF);
    checks++; if (err_o !== 1'b1 || err_code !== 2'd3) begin failures++; $display("FAIL ovr_err got err=%0h code=%0d exp err=1 code=3", err_o, err_code); end
    checks++; if (wr_bus.wr_valid_o !== 1'b1 || wr_bus.wr_addr_o !== 8'h12 || wr_bus.wr_data_o !== 16'h3456) begin failures++; $display("FAIL ovr_fields got v=%0h a=%02h d=%04h exp v=1 a=12 d=3456", wr_bus.wr_valid_o, wr_bus.wr_addr_o, wr_bus.wr_data_o); end
    rx_data = SYNC;
    rx_valid = 1'b1;
    wr_bus.wr_ready_i = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    wr_bus.wr_ready_i = 1'b0;
    checks++; if (wr_bus.wr_valid_o !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL ovr_sync_restart got v=%0h busy=%0h exp v=0 busy=1", wr_bus.wr_valid_o, busy); end
    checks++; if (wr_log.size() !== 1 || err_o !== 1'b0) begin failures++; $display("FAIL ovr_complete got writes=%0d err=%0h exp writes=1 err=0", wr_log.size(), err_o); end
    send_byte(8'h77);
    send_byte(8'h88);
    send_byte(8'h99);
`ifdef UART_CMD_FRAMER_CHECKSUM_EN
    send_byte(xsum(8'h77, 8'h88, 8'h99));
`endif
    checks++; if (wr_bus.wr_addr_o !== 8'h77 || wr_bus.wr_data_o !== 16'h8899) begin failures++; $display("FAIL ovr_second got a=%02h d=%04h exp a=77 d=8899", wr_bus.wr_addr_o, wr_bus.wr_data_o); end
    wr_bus.wr_ready_i = 1'b1;
    tick(1);
    wr_bus.wr_ready_i = 1'b0;
    checks++; if (wr_log.size() !== 2 || err_count !== 8'd1) begin failures++; $display("FAIL ovr_totals got writes=%0d count=%0d exp writes=2 count=1", wr_log.size(), err_count); end
  endtask

  task automatic test_junk_reset();
    do_reset();
    wr_bus.wr_ready_i = 1'b1;
    send_byte(8'h00);
    send_byte(8'hFF);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL junk_ignored got busy=%0h exp=0", busy); end
    send_byte(SYNC);
    send_byte(8'h01);
    checks++; if (busy !== 1'b1 || wr_log.size() !== 0 || err_log.size() !== 0) begin failures++; $display("FAIL junk_partial got busy=%0h writes=%0d errs=%0d exp 1 0 0", busy, wr_log.size(), err_log.size()); end
    do_reset();
    checks++; if (busy !== 1'b0 || wr_bus.wr_valid_o !== 1'b0 || wr_bus.wr_addr_o !== 8'h00 || err_count !== 8'd0 || err_o !== 1'b0) begin failures++; $display("FAIL junk_reset got busy=%0h v=%0h a=%02h cnt=%0d err=%0h exp all 0", busy, wr_bus.wr_valid_o, wr_bus.wr_addr_o, err_count, err_o); end
    wr_bus.wr_ready_i = 1'b1;
    send_packet(8'h5A, 8'hC3, 8'h3C, 1'b0);
    tick(1);
    checks++; if (wr_log.size() !== 1 || wr_log[0] !== 24'h5AC33C || err_log.size() !== 0) begin failures++; $display("FAIL junk_after_reset got writes=%0d errs=%0d exp 1 write 5AC33C, 0 errs", wr_log.size(), err_log.size()); end
    wr_bus.wr_ready_i = 1'b0;
  endtask

  task automatic test_random();
    logic [23:0] exp_wr[$];
    logic [1:0]  exp_err[$];
    logic [7:0]  f[3];
    logic [7:0]  junk;
    int          kind, nbytes, exp_cnt, waited;
    do_reset();
    exp_cnt = 0;
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == SYNC) junk = 8'h00;
        send_byte(junk);
      end
      for (int i = 0; i < 3; i++) f[i] = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 7);
      wr_bus.wr_ready_i = 1'($urandom_range(0, 1));
      send_byte(SYNC);
      if (kind == 0) begin
        // Abandoned packet: inter-byte gap exceeds the limit.
        nbytes = $urandom_range(0, 2);
        for (int i = 0; i < nbytes; i++) send_byte(f[i]);
        tick(TMO);
        exp_err.push_back(2'd1);
        exp_cnt++;
        continue;
      end
      for (int i = 0; i < 3; i++) begin
        tick($urandom_range(0, TMO - 1));
        send_byte(f[i]);
      end
`ifdef UART_CMD_FRAMER_CHECKSUM_EN
      tick($urandom_range(0, TMO - 1));
      if (kind == 1) begin
        send_byte(xsum(f[0], f[1], f[2]) ^ 8'($urandom_range(1, 255)));
        exp_err.push_back(2'd2);
        exp_cnt++;
        continue;
      end
      send_byte(xsum(f[0], f[1], f[2]));
`endif
      exp_wr.push_back({f[0], f[1], f[2]});
      waited = 0;
      while (wr_log.size() < exp_wr.size() && waited < 64) begin
        wr_bus.wr_ready_i = 1'($urandom_range(0, 1));
        tick(1);
        waited++;
      end
      wr_bus.wr_ready_i = 1'b0;
      checks++; if (wr_log.size() !== exp_wr.size()) begin failures++; $display("FAIL rnd_write_wait pkt=%0d got writes=%0d exp=%0d", p, wr_log.size(), exp_wr.size()); end
    end
    tick(2);
    checks++; if (wr_log.size() !== exp_wr.size()) begin failures++; $display("FAIL rnd_write_total got=%0d exp=%0d", wr_log.size(), exp_wr.size()); end
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) begin
      checks++; if (wr_log[i] !== exp_wr[i]) begin failures++; $display("FAIL rnd_write idx=%0d got=%06h exp=%06h", i, wr_log[i], exp_wr[i]); end
    end
    checks++; if (err_log.size() !== exp_err.size()) begin failures++; $display("FAIL rnd_err_total got=%0d exp=%0d", err_log.size(), exp_err.size()); end
    for (int i = 0; i < exp_err.size() && i < err_log.size(); i++) begin
      checks++; if (err_log[i] !== exp_err[i]) begin failures++; $display("FAIL rnd_err idx=%0d got=%0d exp=%0d", i, err_log[i], exp_err[i]); end
    end
    checks++; if (err_count !== 8'(exp_cnt > 255 ? 255 : exp_cnt)) begin failures++; $display("FAIL rnd_err_count got=%0d exp=%0d", err_count, exp_cnt); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 1; i <= 300; i++) begin
`ifdef UART_CMD_FRAMER_CHECKSUM_EN
      send_packet(8'(i), 8'h00, 8'hFF, 1'b1);
`else
      send_byte(SYNC);
      tick(TMO);
`endif
      if (i == 254 || i == 255) begin
        checks++; if (err_count !== 8'(i)) begin failures++; $display("FAIL sat_count_%0d got=%0d exp=%0d", i, err_count, i); end
      end
    end
    tick(1);
    checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL sat_final got=%0d exp=255", err_count); end
    checks++; if (err_log.size() !== 300) begin failures++; $display("FAIL sat_pulses got=%0d exp=300", err_log.size()); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    wr_bus.wr_ready_i = 1'b0;
    tick(1);
    test_reset();
    test_good_packet();
    test_bad_checksum();
    test_timeout();
    test_overrun();
    test_junk_reset();
    test_random();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
